spec_rename_table: RTL and testbench

SPEC_RENAME_TABLE -- requirements
Module: SpecRenameTable

---
 rtl/spec_rename_table_pkg.sv | 19 +
 rtl/spec_rename_table_bypass.sv | 26 ++
 rtl/spec_rename_table.sv | 150 +++++++++++++++
 tb/tb_spec_rename_table.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spec_rename_table_pkg.sv
// rtl/spec_rename_table_pkg.sv - shared widths, sizes and state encoding for the rename table
package spec_rename_table_pkg;

    localparam int ARCH_W = 5;
    localparam int PHYS_W = 7;
    localparam int SLOTS  = 4;
    localparam int DEPTH  = 32;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    // Identity mapping used at reset: arch reg i lives in physical reg i.
    function automatic logic [PHYS_W-1:0] reset_map(input int idx);
        return PHYS_W'(idx);
    endfunction

endpackage

// File: rtl/spec_rename_table_bypass.sv
// rtl/spec_rename_table_bypass.sv - picks the youngest older in-group writer of an arch reg, else the table value
module spec_rename_table_bypass
    import spec_rename_table_pkg::*;
(
    input  logic [ARCH_W-1:0]       lookup_addr,
    input  logic [PHYS_W-1:0]       table_pr,
    input  logic [SLOTS-1:0]        older_wr,
    input  logic [SLOTS*ARCH_W-1:0] older_dest,
    input  logic [SLOTS*PHYS_W-1:0] older_pr,
    output logic [PHYS_W-1:0]       result_pr
);

    // Ascending scan so a later (younger) match overrides an earlier one.
    always_comb begin
        result_pr = table_pr;
        for (int m = 0; m < SLOTS; m++) begin
            if (older_wr[m] && (older_dest[m*ARCH_W +: ARCH_W] == lookup_addr)) begin
                result_pr = older_pr[m*PHYS_W +: PHYS_W];
            end
        end
        if (lookup_addr == '0) begin
            result_pr = '0;
        end
    end

endmodule

// File: rtl/spec_rename_table.sv
// rtl/spec_rename_table.sv - 4-wide speculative register alias table with recovery load and stall
module spec_rename_table
    import spec_rename_table_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rat_stop,
    input  logic                    re_mapping,
    input  logic [DEPTH*PHYS_W-1:0] re_mapping_as,
    input  logic [SLOTS-1:0]        inst_able,
    input  logic [SLOTS*ARCH_W-1:0] inst_src1_addr,
    input  logic [SLOTS*ARCH_W-1:0] inst_src2_addr,
    input  logic [SLOTS-1:0]        inst_dest_able,
    input  logic [SLOTS*ARCH_W-1:0] inst_dest_addr,
    input  logic [SLOTS*PHYS_W-1:0] inst_new_pr,
    output logic                    rename_ready,
    output logic [SLOTS-1:0]        out_able,
    output logic [SLOTS*PHYS_W-1:0] out_src1_pr,
    output logic [SLOTS*PHYS_W-1:0] out_src2_pr,
    output logic [SLOTS*PHYS_W-1:0] out_old_pr,
    output logic [SLOTS*PHYS_W-1:0] out_new_pr
);

    state_e                  state_q, state_d;
    logic [PHYS_W-1:0]       table_q [DEPTH];
    logic [PHYS_W-1:0]       table_d [DEPTH];
    logic [SLOTS-1:0]        out_able_q, out_able_d;
    logic [SLOTS*PHYS_W-1:0] out_src1_q, out_src1_d;
    logic [SLOTS*PHYS_W-1:0] out_src2_q, out_src2_d;
    logic [SLOTS*PHYS_W-1:0] out_old_q, out_old_d;
    logic [SLOTS*PHYS_W-1:0] out_new_q, out_new_d;

    logic [SLOTS-1:0]  slot_wr;
    logic [PHYS_W-1:0] look_src1 [SLOTS];
    logic [PHYS_W-1:0] look_src2 [SLOTS];
    logic [PHYS_W-1:0] look_dest [SLOTS];
    logic              accept;

    always_comb begin
        for (int n = 0; n < SLOTS; n++) begin
            slot_wr[n] = inst_able[n] && inst_dest_able[n]
                         && (inst_dest_addr[n*ARCH_W +: ARCH_W] != '0);
        end
    end

    genvar n;
    generate
        for (n = 0; n < SLOTS; n++) begin : g_slot
            // Only slots older than n may forward into slot n.
            localparam logic [SLOTS-1:0] OLDER_MASK = SLOTS'((1 << n) - 1);
            logic [SLOTS-1:0] older_wr;
            assign older_wr = slot_wr & OLDER_MASK;

            spec_rename_table_bypass u_src1 (
                .lookup_addr (inst_src1_addr[n*ARCH_W +: ARCH_W]),
                .table_pr    (table_q[inst_src1_addr[n*ARCH_W +: ARCH_W]]),
                .older_wr    (older_wr),
                .older_dest  (inst_dest_addr),
                .older_pr    (inst_new_pr),
                .result_pr   (look_src1[n])
            );
            spec_rename_table_bypass u_src2 (
                .lookup_addr (inst_src2_addr[n*ARCH_W +: ARCH_W]),
                .table_pr    (table_q[inst_src2_addr[n*ARCH_W +: ARCH_W]]),
                .older_wr    (older_wr),
                .older_dest  (inst_dest_addr),
                .older_pr    (inst_new_pr),
                .result_pr   (look_src2[n])
            );
            spec_rename_table_bypass u_dest (
                .lookup_addr (inst_dest_addr[n*ARCH_W +: ARCH_W]),
                .table_pr    (table_q[inst_dest_addr[n*ARCH_W +: ARCH_W]]),
                .older_wr    (older_wr),
                .older_dest  (inst_dest_addr),
                .older_pr    (inst_new_pr),
                .result_pr   (look_dest[n])
            );
        end
    endgenerate

    assign rename_ready = !rst && (state_q == ST_NORMAL) && !rat_stop && !re_mapping;
    assign accept       = rename_ready && (inst_able != '0);

    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        out_able_d = out_able_q;
        out_src1_d = out_src1_q;
        out_src2_d = out_src2_q;
        out_old_d  = out_old_q;
        out_new_d  = out_new_q;

        if (re_mapping) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_d[i] = re_mapping_as[i*PHYS_W +: PHYS_W];
            end
            table_d[0] = '0;
            state_d    = ST_RECOVER;
            out_able_d = '0;
        end else if (state_q == ST_RECOVER) begin
            state_d    = ST_NORMAL;
            out_able_d = '0;
        end else if (!rat_stop) begin
            out_able_d = accept ? inst_able : '0;
            if (accept) begin
                for (int s = 0; s < SLOTS; s++) begin
                    out_src1_d[s*PHYS_W +: PHYS_W] = look_src1[s];
                    out_src2_d[s*PHYS_W +: PHYS_W] = look_src2[s];
                    out_old_d[s*PHYS_W +: PHYS_W]  = slot_wr[s] ? look_dest[s] : '0;
                    out_new_d[s*PHYS_W +: PHYS_W]  = slot_wr[s] ? inst_new_pr[s*PHYS_W +: PHYS_W] : '0;
                end
                // Ascending order lets the youngest of equal destinations win.
                for (int s = 0; s < SLOTS; s++) begin
                    if (slot_wr[s]) begin
                        table_d[inst_dest_addr[s*ARCH_W +: ARCH_W]] = inst_new_pr[s*PHYS_W +: PHYS_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= reset_map(i);
            end
            state_q    <= ST_NORMAL;
            out_able_q <= '0;
            out_src1_q <= '0;
            out_src2_q <= '0;
            out_old_q  <= '0;
            out_new_q  <= '0;
        end else begin
            table_q    <= table_d;
            state_q    <= state_d;
            out_able_q <= out_able_d;
            out_src1_q <= out_src1_d;
            out_src2_q <= out_src2_d;
            out_old_q  <= out_old_d;
            out_new_q  <= out_new_d;
        end
    end

    assign out_able    = out_able_q;
    assign out_src1_pr = out_src1_q;
    assign out_src2_pr = out_src2_q;
    assign out_old_pr  = out_old_q;
    assign out_new_pr  = out_new_q;

endmodule

// File: tb/tb_spec_rename_table.sv
// tb/tb_spec_rename_table.sv - randomized scoreboard bench with a sequential-renaming reference model
module tb_spec_rename_table;

    logic         clk = 1'b0;
    logic         rst;
    logic         rat_stop;
    logic         re_mapping;
    logic [223:0] re_mapping_as;
    logic [3:0]   inst_able;
    logic [19:0]  inst_src1_addr;
    logic [19:0]  inst_src2_addr;
    logic [3:0]   inst_dest_able;
    logic [19:0]  inst_dest_addr;
    logic [27:0]  inst_new_pr;
    logic         rename_ready;
    logic [3:0]   out_able;
    logic [27:0]  out_src1_pr;
    logic [27:0]  out_src2_pr;
    logic [27:0]  out_old_pr;
    logic [27:0]  out_new_pr;

    always #5 clk = ~clk;

    spec_rename_table dut (
        .clk            (clk),
        .rst            (rst),
        .rat_stop       (rat_stop),
        .re_mapping     (re_mapping),
        .re_mapping_as  (re_mapping_as),
        .inst_able      (inst_able),
        .inst_src1_addr (inst_src1_addr),
        .inst_src2_addr (inst_src2_addr),
        .inst_dest_able (inst_dest_able),
        .inst_dest_addr (inst_dest_addr),
        .inst_new_pr    (inst_new_pr),
        .rename_ready   (rename_ready),
        .out_able       (out_able),
        .out_src1_pr    (out_src1_pr),
        .out_src2_pr    (out_src2_pr),
        .out_old_pr     (out_old_pr),
        .out_new_pr     (out_new_pr)
    );

    typedef struct packed {
        logic [3:0]      able;
        logic [3:0][6:0] s1;
        logic [3:0][6:0] s2;
        logic [3:0][6:0] old;
        logic [3:0][6:0] nw;
    } exp_t;

    exp_t       q_exp[$];
    exp_t       cur;
    exp_t       mon_e;
    logic [6:0] mtab [32];
    bit         mrec;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        rst            = 1'b0;
        rat_stop       = 1'b0;
        re_mapping     = 1'b0;
        re_mapping_as  = '0;
        inst_able      = '0;
        inst_src1_addr = '0;
        inst_src2_addr = '0;
        inst_dest_able = '0;
        inst_dest_addr = '0;
        inst_new_pr    = '0;
    endtask

    task automatic set_slot(input int n, input bit a, input int s1, input int s2,
                            input bit da, input int d, input int np);
        inst_able[n]              = a;
        inst_src1_addr[n*5 +: 5]  = 5'(s1);
        inst_src2_addr[n*5 +: 5]  = 5'(s2);
        inst_dest_able[n]         = da;
        inst_dest_addr[n*5 +: 5]  = 5'(d);
        inst_new_pr[n*7 +: 7]     = 7'(np);
    endtask

    // Reference: rename the group one instruction at a time against a live map.
    task automatic model_step();
        bit exp_ready;
        int d;
        #1;
        exp_ready = !rst && !mrec && !rat_stop && !re_mapping;
        check("rename_ready", int'(rename_ready), int'(exp_ready));
        if (rst) begin
            for (int i = 0; i < 32; i++) mtab[i] = 7'(i);
            cur  = '0;
            mrec = 1'b0;
        end else if (re_mapping) begin
            for (int i = 0; i < 32; i++) mtab[i] = re_mapping_as[i*7 +: 7];
            cur.able = '0;
            mrec     = 1'b1;
        end else if (mrec) begin
            cur.able = '0;
            mrec     = 1'b0;
        end else if (rat_stop) begin
            cur = cur;
        end else if (inst_able == '0) begin
            cur.able = '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                cur.able[n] = inst_able[n];
                if (inst_able[n]) begin
                    cur.s1[n] = mtab[inst_src1_addr[n*5 +: 5]];
                    cur.s2[n] = mtab[inst_src2_addr[n*5 +: 5]];
                    d = int'(inst_dest_addr[n*5 +: 5]);
                    if (inst_dest_able[n] && d != 0) begin
                        cur.old[n] = mtab[d];
                        cur.nw[n]  = inst_new_pr[n*7 +: 7];
                        mtab[d]    = inst_new_pr[n*7 +: 7];
                    end else begin
                        cur.old[n] = '0;
                        cur.nw[n]  = '0;
                    end
                end
            end
        end
        q_exp.push_back(cur);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                mon_e = q_exp.pop_front();
                check("out_able", int'(out_able), int'(mon_e.able));
                for (int n = 0; n < 4; n++) begin
                    if (mon_e.able[n]) begin
                        check($sformatf("out_src1_pr[%0d]", n), int'(out_src1_pr[n*7 +: 7]), int'(mon_e.s1[n]));
                        check($sformatf("out_src2_pr[%0d]", n), int'(out_src2_pr[n*7 +: 7]), int'(mon_e.s2[n]));
                        check($sformatf("out_old_pr[%0d]", n), int'(out_old_pr[n*7 +: 7]), int'(mon_e.old[n]));
                        check($sformatf("out_new_pr[%0d]", n), int'(out_new_pr[n*7 +: 7]), int'(mon_e.nw[n]));
                    end
                end
            end
        end
    end

    task automatic rand_remap_bus();
        for (int i = 1; i < 32; i++) re_mapping_as[i*7 +: 7] = 7'($urandom_range(0, 127));
        re_mapping_as[6:0] = '0;
    endtask

    task automatic rand_group();
        for (int n = 0; n < 4; n++) begin
            set_slot(n, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                     $urandom_range(1, 127));
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mtab[i] = 7'(i);
        cur  = '0;
        mrec = 1'b0;

        repeat (2) begin @(negedge clk); clear_inputs(); rst = 1'b1; model_step(); end

        @(negedge clk); clear_inputs(); set_slot(0, 1, 5, 0, 1, 5, 40); model_step();

        @(negedge clk); clear_inputs();
        set_slot(0, 1, 1, 2, 1, 3, 40);
        set_slot(1, 1, 3, 4, 0, 0, 0);
        set_slot(2, 1, 6, 7, 1, 3, 41);
        model_step();
        @(negedge clk); clear_inputs(); set_slot(0, 1, 3, 5, 0, 0, 0); model_step();

        @(negedge clk); clear_inputs(); set_slot(0, 1, 2, 2, 1, 0, 50); model_step();
        @(negedge clk); clear_inputs(); set_slot(1, 1, 0, 0, 1, 0, 51); model_step();

        @(negedge clk); clear_inputs(); rand_remap_bus(); re_mapping_as[3*7 +: 7] = 7'd77;
        re_mapping = 1'b1; rat_stop = 1'b1; set_slot(0, 1, 3, 3, 1, 3, 60); model_step();
        @(negedge clk); clear_inputs(); set_slot(0, 1, 3, 3, 1, 3, 60); model_step();
        @(negedge clk); clear_inputs(); set_slot(0, 1, 3, 4, 0, 0, 0); model_step();

        repeat (3) begin
            @(negedge clk); clear_inputs(); rat_stop = 1'b1;
            set_slot(0, 1, 3, 9, 1, 9, 90); set_slot(3, 1, 9, 3, 1, 9, 91); model_step();
        end
        @(negedge clk); clear_inputs(); set_slot(0, 1, 3, 9, 1, 9, 90); set_slot(3, 1, 9, 3, 1, 9, 91); model_step();
        @(negedge clk); clear_inputs(); model_step();

        @(negedge clk); clear_inputs(); rst = 1'b1; set_slot(0, 1, 4, 5, 1, 4, 99); model_step();
        @(negedge clk); clear_inputs(); set_slot(0, 1, 4, 9, 1, 9, 12); model_step();

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            clear_inputs();
            rand_group();
            rst        = ($urandom_range(0, 99) == 0);
            re_mapping = ($urandom_range(0, 99) < 3);
            rat_stop   = ($urandom_range(0, 99) < 20);
            if (re_mapping) rand_remap_bus();
            model_step();
        end

        @(negedge clk); clear_inputs(); model_step();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
